// File: rtl/inst_sram_ctrl_pkg.sv
// Shared constants and types for the instruction-fetch SRAM bridge.
package inst_sram_ctrl_pkg;

  localparam logic [31:0] ZeroWord  = 32'h0000_0000;
  localparam logic        RstEnable = 1'b1;

  typedef logic [3:0] sram_wait_t;

  typedef enum logic {
    InstFetchIdle   = 1'b0,
    InstFetchAccess = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/inst_sram_ctrl.sv
// Instruction-fetch bridge: one-entry fetch buffer in front of an asynchronous
// SRAM read with WAIT_CYCLES extra read cycles; stalls the core on a miss.
module inst_sram_ctrl
  import inst_sram_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned ADDR_W      = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rom_ce_i,
  input  logic [31:0]       rom_addr_i,
  input  logic              inv_i,
  output logic [31:0]       rom_data_o,
  output logic              stall_o,
  output logic              misalign_o,
  output logic [ADDR_W-1:0] sram_addr_o,
  output logic              sram_ce_n_o,
  output logic              sram_oe_n_o,
  output logic              sram_we_n_o,
  input  logic [31:0]       sram_data_i
);

  fetch_state_e r_state;
  sram_wait_t   r_cnt;
  logic [29:0]  r_req_addr;
  logic [29:0]  r_buf_addr;
  logic [31:0]  r_buf_data;
  logic         r_buf_valid;
  logic         r_sram_ce_n;
  logic         r_sram_oe_n;

  logic w_rst_active;
  logic w_idle;
  logic w_hit;

  assign w_rst_active = (rst == RstEnable);
  assign w_idle       = (r_state == InstFetchIdle);
  // Full 30-bit tag so SRAM aliases never alias in the buffer.
  assign w_hit        = r_buf_valid && (r_buf_addr == rom_addr_i[31:2]);

  assign stall_o     = !w_rst_active && rom_ce_i && !(w_idle && w_hit);
  assign rom_data_o  = (!w_rst_active && rom_ce_i && w_idle && w_hit) ? r_buf_data : ZeroWord;
  assign misalign_o  = !w_rst_active && rom_ce_i && (rom_addr_i[1:0] != 2'b00);

  // req_addr only changes on ACCESS entry, so it also holds the pins between accesses.
  assign sram_addr_o = r_req_addr[ADDR_W-1:0];
  assign sram_ce_n_o = r_sram_ce_n;
  assign sram_oe_n_o = r_sram_oe_n;
  assign sram_we_n_o = 1'b1;

  always_ff @(posedge clk) begin
    if (w_rst_active) begin
      r_state     <= InstFetchIdle;
      r_cnt       <= '0;
      r_req_addr  <= '0;
      r_buf_addr  <= '0;
      r_buf_data  <= ZeroWord;
      r_buf_valid <= 1'b0;
      r_sram_ce_n <= 1'b1;
      r_sram_oe_n <= 1'b1;
    end else begin
      unique case (r_state)
        InstFetchIdle: begin
          if (rom_ce_i && !w_hit) begin
            r_state     <= InstFetchAccess;
            r_req_addr  <= rom_addr_i[31:2];
            r_cnt       <= sram_wait_t'(WAIT_CYCLES);
            r_sram_ce_n <= 1'b0;
            r_sram_oe_n <= 1'b0;
          end
        end
        InstFetchAccess: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            r_buf_data  <= sram_data_i;
            r_buf_addr  <= r_req_addr;
            r_buf_valid <= 1'b1;
            r_sram_ce_n <= 1'b1;
            r_sram_oe_n <= 1'b1;
            r_state     <= InstFetchIdle;
          end
        end
      endcase
      // Invalidate overrides a same-edge capture; the data is still written.
      if (inv_i) begin
        r_buf_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_inst_sram_ctrl.sv
// Self-checking bench for inst_sram_ctrl: directed scenarios plus a randomized
// run against a cycle-level behavioural model of the fetch buffer.
module tb_inst_sram_ctrl;

  localparam int unsigned AW = 20;
  localparam int unsigned W  = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        rom_ce;
  logic [31:0] rom_addr;
  logic        inv;

  logic [31:0]   rom_data, rom_data_z;
  logic          stall, stall_z, mis, mis_z;
  logic [AW-1:0] sa, sa_z;
  logic          ce_n, oe_n, we_n, ce_n_z, oe_n_z, we_n_z;
  logic [31:0]   sd, sd_z;

  logic [31:0] mem [256];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Asynchronous SRAM: data only driven while both strobes are low.
  assign sd   = (!ce_n && !oe_n) ? mem[sa[7:0]] : 32'hDEAD_BEEF;
  assign sd_z = (!ce_n_z && !oe_n_z) ? mem[sa_z[7:0]] : 32'hDEAD_BEEF;

  inst_sram_ctrl #(.WAIT_CYCLES(W), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .rom_ce_i(rom_ce), .rom_addr_i(rom_addr), .inv_i(inv),
    .rom_data_o(rom_data), .stall_o(stall), .misalign_o(mis), .sram_addr_o(sa),
    .sram_ce_n_o(ce_n), .sram_oe_n_o(oe_n), .sram_we_n_o(we_n), .sram_data_i(sd)
  );

  inst_sram_ctrl #(.WAIT_CYCLES(0), .ADDR_W(AW)) dut_z (
    .clk(clk), .rst(rst), .rom_ce_i(rom_ce), .rom_addr_i(rom_addr), .inv_i(inv),
    .rom_data_o(rom_data_z), .stall_o(stall_z), .misalign_o(mis_z), .sram_addr_o(sa_z),
    .sram_ce_n_o(ce_n_z), .sram_oe_n_o(oe_n_z), .sram_we_n_o(we_n_z), .sram_data_i(sd_z)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #4;
  endtask

  task automatic drive(input logic c, input logic [31:0] a, input logic i);
    rom_ce   = c;
    rom_addr = a;
    inv      = i;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      drive(1'b0, 32'h0, 1'b0);
      step();
    end
  endtask

  // Holds a fetch until served; returns stall cycle count and served data.
  task automatic fetch(input bit z, input logic [31:0] a, output int n, output logic [31:0] d);
    n = 0;
    d = 32'hx;
    for (int k = 0; k < 20; k++) begin
      drive(1'b1, a, 1'b0);
      settle();
      if (!(z ? stall_z : stall)) begin
        d = z ? rom_data_z : rom_data;
        break;
      end
      n++;
      step();
    end
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, 32'h0, 1'b0);
    step();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 32'h0, 1'b0);
      settle();
      checks++;
      if (stall !== 1'b0 || rom_data !== 32'h0) begin
        errors++;
        $display("FAIL reset_outputs cyc%0d: stall=%b data=%h, want 0/0", k, stall, rom_data);
      end
      checks++;
      if (ce_n !== 1'b1 || oe_n !== 1'b1 || we_n !== 1'b1 || sa !== '0 || mis !== 1'b0) begin
        errors++;
        $display("FAIL reset_sram cyc%0d: ce_n=%b oe_n=%b we_n=%b addr=%h mis=%b, want 1/1/1/0/0",
                 k, ce_n, oe_n, we_n, sa, mis);
      end
      step();
    end
  endtask

  task automatic test_miss_then_hit();
    logic es, ec;
    rst = 1'b0;
    for (int k = 0; k <= 4; k++) begin
      drive(1'b1, 32'h0, 1'b0);
      settle();
      es = (k <= 3);
      ec = !(k >= 1 && k <= 3);
      checks++;
      if (stall !== es || ce_n !== ec) begin
        errors++;
        $display("FAIL miss_hit cyc%0d: stall=%b ce_n=%b, want %b/%b", k, stall, ce_n, es, ec);
      end
      if (k == 4) begin
        checks++;
        if (rom_data !== 32'h2401_0005) begin
          errors++;
          $display("FAIL miss_hit_data: got %h want 24010005", rom_data);
        end
      end
      step();
    end
  endtask

  task automatic test_sequential();
    int n;
    logic [31:0] d;
    drive(1'b0, 32'h0, 1'b1);
    step();
    fetch(1'b0, 32'h0, n, d);
    checks++;
    if (n != 4 || d !== mem[0]) begin
      errors++;
      $display("FAIL seq_word0: stalls=%0d data=%h, want 4/%h", n, d, mem[0]);
    end
    fetch(1'b0, 32'h4, n, d);
    checks++;
    if (n != 4 || d !== mem[1]) begin
      errors++;
      $display("FAIL seq_word1: stalls=%0d data=%h, want 4/%h", n, d, mem[1]);
    end
    fetch(1'b0, 32'h4, n, d);
    checks++;
    if (n != 0 || d !== mem[1]) begin
      errors++;
      $display("FAIL seq_rehit: stalls=%0d data=%h, want 0/%h", n, d, mem[1]);
    end
  endtask

  task automatic test_addr_change();
    logic es, ec;
    drive(1'b0, 32'h0, 1'b1);
    step();
    for (int k = 0; k <= 8; k++) begin
      drive(1'b1, (k >= 2) ? 32'h8 : 32'h0, 1'b0);
      settle();
      es = (k <= 7);
      ec = !((k >= 1 && k <= 3) || (k >= 5 && k <= 7));
      checks++;
      if (stall !== es || ce_n !== ec) begin
        errors++;
        $display("FAIL addr_chg cyc%0d: stall=%b ce_n=%b, want %b/%b", k, stall, ce_n, es, ec);
      end
      if (k >= 1 && k <= 7 && k != 4) begin
        checks++;
        if (sa !== ((k <= 3) ? 20'd0 : 20'd2)) begin
          errors++;
          $display("FAIL addr_chg_sram cyc%0d: got %h want %h", k, sa, (k <= 3) ? 0 : 2);
        end
      end
      if (k == 4 || k == 8) begin
        checks++;
        if (rom_data !== ((k == 8) ? mem[2] : 32'h0)) begin
          errors++;
          $display("FAIL addr_chg_data cyc%0d: got %h want %h", k, rom_data,
                   (k == 8) ? mem[2] : 32'h0);
        end
      end
      step();
    end
  endtask

  task automatic test_inv_capture();
    logic es, ec;
    drive(1'b0, 32'h0, 1'b1);
    step();
    for (int k = 0; k <= 8; k++) begin
      drive(1'b1, 32'hC, k == 3);
      settle();
      es = (k <= 7);
      ec = !((k >= 1 && k <= 3) || (k >= 5 && k <= 7));
      checks++;
      if (stall !== es || ce_n !== ec) begin
        errors++;
        $display("FAIL inv_capture cyc%0d: stall=%b ce_n=%b, want %b/%b", k, stall, ce_n, es, ec);
      end
      if (k == 8) begin
        checks++;
        if (rom_data !== mem[3]) begin
          errors++;
          $display("FAIL inv_capture_data: got %h want %h", rom_data, mem[3]);
        end
      end
      step();
    end
  endtask

  task automatic test_wait0();
    int n;
    logic [31:0] d;
    idle(4);
    drive(1'b0, 32'h0, 1'b1);
    step();
    fetch(1'b1, 32'h10, n, d);
    checks++;
    if (n != 2 || d !== mem[4]) begin
      errors++;
      $display("FAIL wait0: stalls=%0d data=%h, want 2/%h", n, d, mem[4]);
    end
    idle(6);
  endtask

  task automatic test_rst_mid_misalign();
    int n;
    logic [31:0] d;
    drive(1'b0, 32'h0, 1'b1);
    step();
    for (int k = 0; k <= 3; k++) begin
      rst = (k == 2);
      drive(1'b1, 32'h14, 1'b0);
      settle();
      if (k == 2) begin
        checks++;
        if (stall !== 1'b0 || rom_data !== 32'h0) begin
          errors++;
          $display("FAIL rst_mid_during: stall=%b data=%h, want 0/0", stall, rom_data);
        end
      end
      if (k == 3) begin
        checks++;
        if (ce_n !== 1'b1 || oe_n !== 1'b1 || stall !== 1'b1) begin
          errors++;
          $display("FAIL rst_mid_after: ce_n=%b oe_n=%b stall=%b, want 1/1/1", ce_n, oe_n, stall);
        end
      end
      step();
    end
    rst = 1'b0;
    fetch(1'b0, 32'h14, n, d);
    checks++;
    if (n != 3 || d !== mem[5]) begin
      errors++;
      $display("FAIL rst_mid_refetch: stalls=%0d data=%h, want 3/%h", n, d, mem[5]);
    end
    drive(1'b1, 32'h6, 1'b0);
    settle();
    checks++;
    if (mis !== 1'b1 || stall !== 1'b1) begin
      errors++;
      $display("FAIL misalign: mis=%b stall=%b, want 1/1", mis, stall);
    end
    step();
    fetch(1'b0, 32'h6, n, d);
    checks++;
    if (n != 3 || d !== mem[1]) begin
      errors++;
      $display("FAIL misalign_fetch: stalls=%0d data=%h, want 3/%h", n, d, mem[1]);
    end
  endtask

  task automatic test_random();
    logic [29:0] words [6];
    logic        m_valid, m_hit, m_idle, c, i, r;
    logic [29:0] m_baddr, m_pend, w;
    logic [31:0] m_bdata, a, e_data;
    logic [1:0]  lo;
    logic        e_stall, e_mis;
    int          m_busy;
    words[0] = 30'd0;
    words[1] = 30'd1;
    words[2] = 30'd2;
    words[3] = 30'd3;
    words[4] = 30'(1 << AW) + 30'd1;
    words[5] = 30'(1 << 29);
    rst = 1'b1;
    drive(1'b0, 32'h0, 1'b0);
    step();
    rst = 1'b0;
    m_valid = 1'b0; m_baddr = '0; m_bdata = '0; m_pend = '0; m_busy = 0;
    for (int k = 0; k < 400; k++) begin
      c  = ($urandom_range(0, 9) < 8);
      w  = words[$urandom_range(0, 5)];
      lo = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      a  = {w, lo};
      i  = ($urandom_range(0, 19) == 0);
      r  = ($urandom_range(0, 49) == 0);
      rst = r;
      drive(c, a, i);
      settle();
      m_idle  = (m_busy == 0);
      m_hit   = m_valid && (m_baddr == a[31:2]);
      e_stall = !r && c && !(m_idle && m_hit);
      e_data  = (!r && c && m_idle && m_hit) ? m_bdata : 32'h0;
      e_mis   = !r && c && (lo != 2'b00);
      checks++;
      if (stall !== e_stall || rom_data !== e_data || mis !== e_mis) begin
        errors++;
        $display("FAIL rand_core cyc%0d: stall=%b data=%h mis=%b, want %b/%h/%b",
                 k, stall, rom_data, mis, e_stall, e_data, e_mis);
      end
      checks++;
      if (ce_n !== m_idle || oe_n !== m_idle || we_n !== 1'b1 ||
          (!m_idle && sa !== m_pend[AW-1:0])) begin
        errors++;
        $display("FAIL rand_sram cyc%0d: ce_n=%b oe_n=%b we_n=%b addr=%h, want %b/%b/1/%h",
                 k, ce_n, oe_n, we_n, sa, m_idle, m_idle, m_pend[AW-1:0]);
      end
      step();
      if (r) begin
        m_valid = 1'b0; m_baddr = '0; m_bdata = '0; m_pend = '0; m_busy = 0;
      end else begin
        if (m_idle) begin
          if (c && !m_hit) begin
            m_busy = W + 1;
            m_pend = a[31:2];
          end
        end else begin
          m_busy--;
          if (m_busy == 0) begin
            m_bdata = mem[m_pend[7:0]];
            m_baddr = m_pend;
            m_valid = 1'b1;
          end
        end
        if (i) m_valid = 1'b0;
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 256; k++) mem[k] = $urandom;
    mem[0] = 32'h2401_0005;
    test_reset();
    test_miss_then_hit();
    test_sequential();
    test_addr_change();
    test_inv_capture();
    test_wait0();
    test_rst_mid_misalign();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1);
  end

endmodule

// File: doc/inst_sram_ctrl.md
# inst_sram_ctrl

Instruction-fetch bridge between the core's ROM port (`rom_ce_o`/`rom_addr_o`/`rom_data_i`) and an external 32-bit asynchronous SRAM with programmable wait states.

- Holds a one-entry fetch buffer (last fetched word plus its address).
- Serves repeat fetches of the buffered address with no stall.
- Runs a multi-cycle SRAM read on a miss and asserts `stall_o` so the core holds its PC until the word is buffered.

## Interface
Parameters:
- `WAIT_CYCLES`, default 2: extra SRAM read cycles beyond one; legal range 0..15.
- `ADDR_W`, default 20: SRAM word-address width; legal range 1..30.

Ports:
- `clk`  in  1  clock; everything is on the rising edge.
- `rst`  in  1  synchronous, active-high reset (`RstEnable` = 1).
- `rom_ce_i`  in  1  fetch enable from the core's `rom_ce_o`.
- `rom_addr_i`  in  32 (`InstAddrBus`)  byte address from the core's `rom_addr_o`.
- `inv_i`  in  1  invalidate the fetch buffer.
- `rom_data_o`  out  32 (`InstBus`)  instruction to the core's `rom_data_i`.
- `stall_o`  out  1  fetch not yet served; the core holds its PC.
- `misalign_o`  out  1  `rom_addr_i[1:0]` is nonzero while `rom_ce_i` is high.
- `sram_addr_o`  out  ADDR_W  SRAM word address.
- `sram_ce_n_o`  out  1  SRAM chip enable, active low.
- `sram_oe_n_o`  out  1  SRAM output enable, active low.
- `sram_we_n_o`  out  1  SRAM write enable, active low; tied to 1.
- `sram_data_i`  in  32  SRAM read data.

## Operation
- Registered state:
  - `state` ∈ {IDLE, ACCESS}
  - `cnt[3:0]`
  - `req_addr[29:0]`
  - `buf_addr[29:0]`
  - `buf_data[31:0]`
  - `buf_valid`
- `hit` = `buf_valid` && `buf_addr` == `rom_addr_i[31:2]`. The full 30-bit compare is made even though the SRAM decodes only ADDR_W bits.
- `stall_o` = `rom_ce_i` && !(state==IDLE && `hit`), forced 0 while `rst` is high. It is combinational.
- `rom_data_o` = `buf_data` when `rom_ce_i` && `hit` && state==IDLE, else `ZeroWord`.
- `misalign_o` is combinational and informational only. The fetch proceeds using bits `[ADDR_W+1:2]`.

IDLE:
- `rom_ce_i` && !`hit` → go to ACCESS.
  - `req_addr` <= `rom_addr_i[31:2]`
  - `cnt` <= WAIT_CYCLES
- Otherwise stay in IDLE.

ACCESS:
- Drive `sram_addr_o` = `req_addr[ADDR_W-1:0]`, `sram_ce_n_o` = 0, `sram_oe_n_o` = 0.
- `cnt` != 0 → decrement `cnt`.
- `cnt` == 0 → capture and return to IDLE:
  - `buf_data` <= `sram_data_i`
  - `buf_addr` <= `req_addr`
  - `buf_valid` <= 1
  - state <= IDLE
- Outside ACCESS, both SRAM strobes are 1 and `sram_addr_o` holds its last value.

Boundary rules:
- **Address change during ACCESS** (core violated hold, or redirect): the in-flight read completes with `req_addr`. The next IDLE compare then misses and starts a new access. No access is aborted.
- **`rom_ce_i` falls during ACCESS:** the access still completes and is buffered. `stall_o` = 0 and `rom_data_o` = 0 while `rom_ce_i` is low.
- **`inv_i`:** sets `buf_valid` <= 0 next edge. If it coincides with the ACCESS capture edge, `inv_i` wins: data is written but `buf_valid` = 0. `inv_i` never aborts an access.
- **`rst` mid-access:** the next cycle is IDLE with strobes high and the buffer invalid. The SRAM read is discarded.
- **Wrap-around:** address bits above ADDR_W+1 alias in the SRAM but never alias in the buffer.

## Timing
- Reset values:
  - state IDLE, `cnt` 0, `req_addr` 0, `buf_addr` 0, `buf_data` 0, `buf_valid` 0
  - `sram_addr_o` 0, `sram_ce_n_o` 1, `sram_oe_n_o` 1, `sram_we_n_o` 1
  - `rom_data_o` 0, `stall_o` 0, `misalign_o` 0
- **Hit:** 0 stall cycles; data is valid in the same cycle as the address.
- **Miss presented in cycle N:**
  - `stall_o` is high in cycles N .. N+1+WAIT_CYCLES.
  - ACCESS spans cycles N+1 .. N+1+WAIT_CYCLES.
  - Capture occurs on the edge ending cycle N+1+WAIT_CYCLES.
  - Cycle N+2+WAIT_CYCLES: `stall_o` = 0 and `rom_data_o` is valid.
  - Miss penalty: WAIT_CYCLES+2 cycles.
- SRAM data must be stable by the end of the last ACCESS cycle. The SRAM sees WAIT_CYCLES+1 cycles of asserted strobes.

## Structure
- `defines.v` already holds `RegBus`, `InstBus`, `InstAddrBus`, `ZeroWord`, `RstEnable` and `ChipEnable`.
- Add to `defines.v`: `InstFetchIdle` and `InstFetchAccess` (1-bit state codes) and `SramWaitBus` [3:0].
- Single module; no sub-module is warranted.
- The top level instantiates it between the core's ROM port and the SRAM pins. The core's PC and IF/ID registers must honour `stall_o`.

## Test plan
- **Reset:** hold `rst` 3 cycles with `rom_ce_i` = 1 → `stall_o` 0, `rom_data_o` 0, all SRAM strobes 1.
- **Miss then hit** (WAIT_CYCLES = 2): SRAM word 0x24010005 at word 0x000; core presents address 0x00000000 in cycle 0.
  - `stall_o` is high in cycles 0–3; `sram_ce_n_o` is low in cycles 1–3.
  - In cycle 4, `rom_data_o` = 0x24010005 and `stall_o` = 0.
- **Sequential fetch:** present 0x00000000 then 0x00000004 → two misses of 4 stall cycles each.
  - Re-present 0x00000004 → 0 stall cycles.
- **Address change mid-ACCESS:** change 0x00 → 0x08 in cycle 2 → `sram_addr_o` stays 0 through cycle 3.
  - A new access to word 2 starts in cycle 5; 0x08 data appears in cycle 8.
- **Invalidate on the capture edge:** assert `inv_i` in cycle 3 of a miss → cycle 4 misses again and a fresh ACCESS starts.
  - Separately, with WAIT_CYCLES = 0, `stall_o` is high for exactly 2 cycles.
- **Reset mid-access and misalignment:** `rst` in cycle 2 of a miss → cycle 3 IDLE, strobes 1, next fetch misses.
  - Address 0x00000006 → `misalign_o` = 1 and word 1 is fetched.
